// File: rtl/nn_mlp_seq_engine.sv
// Time-multiplexed 2-layer MLP: one shared signed MAC, weights streamed from a synchronous ROM.
// Vector in (LOAD) -> ReLU-clamped hidden layer (L1) -> linear clamped outputs (L2) -> STREAM.
module nn_mlp_seq_engine #(
  parameter int N_IN   = 36,
  parameter int N_HID  = 20,
  parameter int N_OUT  = 10,
  parameter int IN_W   = 9,
  parameter int W_W    = 8,
  parameter int HID_W  = 10,
  parameter int OUT_W  = 11,
  parameter int ACC_W  = 24,
  parameter int SHIFT1 = 7,
  parameter int SHIFT2 = 7,
  localparam int WA_W  = $clog2(N_HID * (N_IN + 1) + N_OUT * (N_HID + 1)),
  localparam int OI_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             w_en,
  output logic [WA_W-1:0]  w_addr,
  input  logic [W_W-1:0]   w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [OI_W-1:0]  out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int MAX_LEN = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int PW      = $clog2(MAX_LEN + 2);
  localparam int MAX_NRN = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int NW      = $clog2(MAX_NRN + 1);
  localparam int XI_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int HI_W    = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int OP_W    = (IN_W > HID_W) ? IN_W : HID_W;
  localparam int PROD_W  = OP_W + W_W;
  localparam logic signed [ACC_W-1:0] HMAX = ACC_W'((1 << (HID_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {StLoad, StL1, StL2, StStream} state_t;

  state_t                   r_state;
  logic [PW-1:0]            r_pos;   // element index in LOAD, cycle-within-neuron in L1/L2
  logic [NW-1:0]            r_nrn;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [IN_W-1:0]   r_x [N_IN];
  logic signed [HID_W-1:0]  r_h [N_HID];
  logic signed [OUT_W-1:0]  r_y [N_OUT];

  logic [XI_W-1:0]          w_xi;
  logic [HI_W-1:0]          w_hi;
  logic signed [OP_W-1:0]   w_op;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_sh1;
  logic signed [ACC_W-1:0]  w_sh2;
  logic signed [HID_W-1:0]  w_hclamp;
  logic signed [OUT_W-1:0]  w_yclamp;
  logic [PW-1:0]            w_len;
  logic                     w_last_nrn;
  logic                     w_more;
  logic                     w_in_hs;
  logic                     w_l1_wr;
  logic                     w_l2_wr;

  always_comb begin
    // Data on w_data in cycle p belongs to the read issued in cycle p-1.
    w_xi   = XI_W'(r_pos - PW'(1));
    w_hi   = HI_W'(r_pos - PW'(1));
    w_op   = (r_state == StL2) ? OP_W'(r_h[w_hi]) : OP_W'(r_x[w_xi]);
    w_prod = PROD_W'(w_op) * PROD_W'($signed(w_data));
    w_sum  = r_acc + ACC_W'($signed(w_data));
    w_sh1  = w_sum >>> SHIFT1;
    w_sh2  = w_sum >>> SHIFT2;

    if (w_sh1[ACC_W-1])   w_hclamp = '0;
    else if (w_sh1 > HMAX) w_hclamp = HID_W'(HMAX);
    else                   w_hclamp = HID_W'(w_sh1);

    if (w_sh2 < YMIN)      w_yclamp = OUT_W'(YMIN);
    else if (w_sh2 > YMAX) w_yclamp = OUT_W'(YMAX);
    else                   w_yclamp = OUT_W'(w_sh2);

    w_len      = (r_state == StL2) ? PW'(N_HID) : PW'(N_IN);
    w_last_nrn = (r_state == StL2) ? (r_nrn == NW'(N_OUT - 1)) : (r_nrn == NW'(N_HID - 1));
    w_more     = !(w_last_nrn && (r_state == StL2));
    w_in_hs    = (r_state == StLoad) && in_valid && in_ready;
    w_l1_wr    = (r_state == StL1) && (r_pos == PW'(N_IN + 1));
    w_l2_wr    = (r_state == StL2) && (r_pos == PW'(N_HID + 1));
  end

  // Vector and activation buffers keep their contents across reset.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_x[XI_W'(r_pos)] <= in_data;
    if (w_l1_wr) r_h[HI_W'(r_nrn)] <= w_hclamp;
    if (w_l2_wr) r_y[OI_W'(r_nrn)] <= w_yclamp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StLoad;
      r_pos     <= '0;
      r_nrn     <= '0;
      r_acc     <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (r_state)
        StLoad: begin
          if (in_valid && in_ready) begin
            if (r_pos == PW'(N_IN - 1)) begin
              r_pos    <= '0;
              r_nrn    <= '0;
              r_acc    <= '0;
              r_state  <= StL1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              w_en     <= 1'b1;
              w_addr   <= '0;
            end else begin
              r_pos <= r_pos + PW'(1);
            end
          end
        end
        StL1, StL2: begin
          // Weight addresses are contiguous across both layers, so w_addr only increments.
          if (r_pos == w_len + PW'(1)) begin
            r_acc <= '0;
            r_pos <= '0;
            if (w_last_nrn) begin
              r_nrn   <= '0;
              r_state <= (r_state == StL1) ? StL2 : StStream;
            end else begin
              r_nrn <= r_nrn + NW'(1);
            end
            w_en <= w_more;
            if (w_more) w_addr <= w_addr + WA_W'(1);
          end else begin
            if (r_pos != '0) r_acc <= r_acc + ACC_W'(w_prod);
            r_pos <= r_pos + PW'(1);
            if (r_pos == w_len) w_en <= 1'b0;
            else                w_addr <= w_addr + WA_W'(1);
          end
        end
        StStream: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= r_y[0];
            out_idx   <= '0;
            out_last  <= (N_OUT == 1);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_idx   <= '0;
              out_data  <= '0;
              r_pos     <= '0;
              r_state   <= StLoad;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_idx  <= out_idx + OI_W'(1);
              out_data <= r_y[OI_W'(out_idx + OI_W'(1))];
              out_last <= ((out_idx + OI_W'(1)) == OI_W'(N_OUT - 1));
            end
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mlp_seq_engine.sv
// Self-checking bench for nn_mlp_seq_engine: ROM model, randomized vectors and handshakes,
// integer reference model of the two layers, per-cycle output monitor.
module tb_nn_mlp_seq_engine;

  localparam int N_IN   = 36;
  localparam int N_HID  = 20;
  localparam int N_OUT  = 10;
  localparam int IN_W   = 9;
  localparam int W_W    = 8;
  localparam int HID_W  = 10;
  localparam int OUT_W  = 11;
  localparam int ACC_W  = 24;
  localparam int SHIFT1 = 7;
  localparam int SHIFT2 = 7;
  localparam int N_W    = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
  localparam int B2     = N_HID * (N_IN + 1);
  localparam int LAT    = N_HID * (N_IN + 2) + N_OUT * (N_HID + 2) + 1;
  localparam int WA_W   = $clog2(N_W);
  localparam int OI_W   = $clog2(N_OUT);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             w_en;
  logic [WA_W-1:0]  w_addr;
  logic [W_W-1:0]   w_data = '0;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [OI_W-1:0]  out_idx;
  logic             out_last;
  logic             busy;

  nn_mlp_seq_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int rom_v [N_W];
  int xv [N_IN];
  int ey [N_OUT];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_idx    = 0;
  int m_done   = 0;
  int wen_cnt  = 0;
  int first_cyc = -1;
  int hs_cyc   = 0;
  bit m_seen   = 1'b0;
  bit force_stall = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_en) w_data <= W_W'(rom_v[w_addr]);
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic int wrap_acc(input longint v);
    longint t;
    t = v <<< (64 - ACC_W);
    return int'(t >>> (64 - ACC_W));
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model();
    int     hv [N_HID];
    longint acc;
    for (int j = 0; j < N_HID; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += longint'(xv[i]) * rom_v[j * (N_IN + 1) + i];
      acc += rom_v[j * (N_IN + 1) + N_IN];
      hv[j] = clampi(wrap_acc(acc) >>> SHIFT1, 0, (1 << (HID_W - 1)) - 1);
    end
    for (int k = 0; k < N_OUT; k++) begin
      acc = 0;
      for (int j = 0; j < N_HID; j++) acc += longint'(hv[j]) * rom_v[B2 + k * (N_HID + 1) + j];
      acc += rom_v[B2 + k * (N_HID + 1) + N_HID];
      ey[k] = clampi(wrap_acc(acc) >>> SHIFT2, -(1 << (OUT_W - 1)), (1 << (OUT_W - 1)) - 1);
    end
  endtask

  task automatic set_rom_const(input int w1, input int b1, input int w2, input int b2);
    for (int a = 0; a < N_W; a++) begin
      if (a < B2) rom_v[a] = ((a % (N_IN + 1)) == N_IN) ? b1 : w1;
      else        rom_v[a] = (((a - B2) % (N_HID + 1)) == N_HID) ? b2 : w2;
    end
  endtask

  task automatic set_rom_rand(input int mag);
    for (int a = 0; a < N_W; a++) rom_v[a] = int'($urandom_range(2 * mag)) - mag;
  endtask

  task automatic set_x_const(input int v);
    for (int i = 0; i < N_IN; i++) xv[i] = v;
  endtask

  task automatic set_x_rand(input int mag);
    for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(2 * mag)) - mag;
  endtask

  // Output monitor: expected index advances only on a handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_idx = 0;
    end else begin
      if (w_en) wen_cnt++;
      if (out_valid) begin
        if (!m_seen) begin
          m_seen    = 1'b1;
          first_cyc = cyc;
        end
        chk("out_idx", int'(out_idx), m_idx);
        chk("out_data", int'($signed(out_data)), ey[m_idx]);
        chk("out_last", int'(out_last), int'(m_idx == N_OUT - 1));
        if (out_ready) begin
          if (m_idx == N_OUT - 1) begin
            m_idx = 0;
            m_done++;
          end else begin
            m_idx++;
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = force_stall ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  task automatic send_vec(input int gap_pct);
    for (int i = 0; i < N_IN; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = IN_W'(xv[i]);
      if (i == N_IN - 1) begin
        @(negedge clk);
        chk("busy_in_load", int'(busy), 0);
        chk("in_ready_in_load", int'(in_ready), 1);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    hs_cyc   = cyc;
    chk("busy_after_last", int'(busy), 1);
    chk("in_ready_after_last", int'(in_ready), 0);
  endtask

  task automatic run_vec(input int gap_pct, input bit stall);
    int target;
    int n;
    model();
    m_seen      = 1'b0;
    first_cyc   = -1;
    wen_cnt     = 0;
    target      = m_done + 1;
    force_stall = stall;
    send_vec(gap_pct);
    if (stall) begin
      n = 0;
      while (!out_valid && n < 3000) begin
        @(negedge clk);
        n++;
      end
      repeat (50) @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_idx", int'(out_idx), 0);
      chk("stall_data", int'($signed(out_data)), ey[0]);
      force_stall = 1'b0;
    end
    n = 0;
    while (m_done < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("stream_done", m_done, target);
    chk("latency", first_cyc - hs_cyc, LAT);
    chk("w_en_cycles", wen_cnt, N_W);
    @(posedge clk);
    #1;
    chk("in_ready_after_stream", int'(in_ready), 1);
    chk("busy_after_stream", int'(busy), 0);
    chk("valid_after_stream", int'(out_valid), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_w_en"}, int'(w_en), 0);
    chk({tag, "_w_addr"}, int'(w_addr), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_idx"}, int'(out_idx), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    set_rom_const(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed cases pin the reference model as well as the DUT.
    set_x_const(100);
    set_rom_const(10, 0, 1, 0);
    model();
    chk("pin_h281_y43", ey[0], 43);
    run_vec(0, 1'b0);

    set_rom_const(30, 0, 1, 0);
    model();
    chk("pin_hsat_y79", ey[N_OUT - 1], 79);
    run_vec(25, 1'b1);

    set_x_const(0);
    set_rom_const(0, -128, 0, -128);
    model();
    chk("pin_relu_bias_neg1", ey[3], -1);
    run_vec(0, 1'b0);

    set_x_const(1);
    set_rom_const(4, 0, 127, 0);
    model();
    chk("pin_h1_y19", ey[5], 19);
    run_vec(0, 1'b0);

    set_x_const(100);
    set_rom_const(30, 0, -128, 0);
    model();
    chk("pin_yclamp_neg", ey[0], -1024);
    run_vec(10, 1'b0);

    // Random data: each set runs gap-free and then with input gaps.
    for (int r = 0; r < 5; r++) begin
      set_x_rand((r % 2 == 0) ? 255 : 40);
      set_rom_rand((r < 2) ? 127 : ((r < 4) ? 20 : 4));
      run_vec(0, 1'b0);
      run_vec(50, r == 2);
    end

    // Abort mid-L1, then the same vector must produce clean results.
    set_x_rand(255);
    set_rom_rand(30);
    model();
    send_vec(30);
    repeat (200) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_output_after_abort", int'(out_valid), 0);
    @(posedge clk);
    #1;
    run_vec(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
